// File: rtl/i2s_wavetable_synth.sv
// Polyphonic wavetable synth: voices are mixed one per cycle with saturation and streamed as I2S, same word on L and R.
// A mix finishes NUM_VOICES+2 cycles after the LRCLK tick; there is no backpressure, a tick landing mid-mix is dropped and flags overrun.
module i2s_wavetable_synth #(
    parameter int NUM_VOICES = 12,
    parameter int SAMPLE_W   = 24,
    parameter int TABLE_AW   = 3,
    parameter int FRAC_W     = 8,
    parameter int ADDR_W     = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SCLK,
    input  logic                  LRCLK,
    input  logic                  Din,
    output logic                  Dout,
    input  logic [NUM_VOICES-1:0] key_on,
    input  logic [2:0]            gain_shift,
    input  logic                  bypass,
    input  logic [ADDR_W-1:0]     ram_address,
    input  logic                  ram_write,
    input  logic [31:0]           ram_writedata,
    output logic [31:0]           ram_readdata,
    output logic                  overrun
);
    localparam int PH_W  = TABLE_AW + FRAC_W;
    localparam int TBL_N = 1 << TABLE_AW;
    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + VW;
    localparam int BC_W  = $clog2(SAMPLE_W + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_SAT   = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(VW+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(VW+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    logic sclk_s1, sclk_s2, sclk_d;
    logic lr_s1, lr_s2, lr_d;
    logic din_s1, din_s2;
    logic sclk_fall, lr_edge, tick;

    // Synchronisers stay out of reset so a level held across reset is never seen as an edge.
    always_ff @(posedge CLK) begin
        sclk_s1 <= SCLK;
        sclk_s2 <= sclk_s1;
        sclk_d  <= sclk_s2;
        lr_s1   <= LRCLK;
        lr_s2   <= lr_s1;
        lr_d    <= lr_s2;
        din_s1  <= Din;
        din_s2  <= din_s1;
    end

    assign sclk_fall = sclk_d & ~sclk_s2;
    assign lr_edge   = lr_d ^ lr_s2;
    assign tick      = lr_s2 & ~lr_d;

    logic signed [SAMPLE_W-1:0] wtable [TBL_N];
    logic [PH_W-1:0]            inc    [NUM_VOICES];
    logic [PH_W-1:0]            phase  [NUM_VOICES];

    logic                is_tbl, is_inc;
    logic [ADDR_W-1:0]   inc_off;
    logic [TABLE_AW-1:0] tbl_sel;
    logic [VW-1:0]       inc_sel;

    assign is_tbl  = ram_address < ADDR_W'(TBL_N);
    assign inc_off = ram_address - ADDR_W'(TBL_N);
    assign is_inc  = !is_tbl && (inc_off < ADDR_W'(NUM_VOICES));
    assign tbl_sel = ram_address[TABLE_AW-1:0];
    assign inc_sel = inc_off[VW-1:0];

    // Read data is taken from the pre-write contents, so a same-cycle write/read returns old data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < TBL_N; i++) wtable[i] <= '0;
            for (int i = 0; i < NUM_VOICES; i++) inc[i] <= '0;
            ram_readdata <= '0;
        end else begin
            if (ram_write && is_tbl) wtable[tbl_sel] <= ram_writedata[31 -: SAMPLE_W];
            if (ram_write && is_inc) inc[inc_sel] <= ram_writedata[PH_W-1:0];
            if (is_tbl)
                ram_readdata <= 32'($unsigned(wtable[tbl_sel])) << (32 - SAMPLE_W);
            else if (is_inc)
                ram_readdata <= 32'(inc[inc_sel]);
            else
                ram_readdata <= '0;
        end
    end

    logic [1:0]                 state;
    logic [VW-1:0]              vcnt;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    addend;
    logic signed [ACC_W-1:0]    shifted;
    logic [TABLE_AW-1:0]        rd_idx;
    logic signed [SAMPLE_W-1:0] sat_val;
    logic signed [SAMPLE_W-1:0] sample_hold;

    assign rd_idx  = phase[vcnt][PH_W-1:FRAC_W];
    assign addend  = key_on[vcnt] ? ACC_W'(wtable[rd_idx]) : '0;
    assign shifted = acc >>> gain_shift;

    always_comb begin
        sat_val = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX)
            sat_val = SAT_MAX[SAMPLE_W-1:0];
        else if (shifted < SAT_MIN)
            sat_val = SAT_MIN[SAMPLE_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            vcnt        <= '0;
            acc         <= '0;
            sample_hold <= '0;
            overrun     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) phase[v] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state <= ST_ACCUM;
                        vcnt  <= '0;
                        acc   <= '0;
                        for (int v = 0; v < NUM_VOICES; v++)
                            phase[v] <= key_on[v] ? phase[v] + inc[v] : '0;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + addend;
                    if (vcnt == VW'(NUM_VOICES - 1))
                        state <= ST_SAT;
                    else
                        vcnt <= vcnt + 1'b1;
                end
                ST_SAT: begin
                    sample_hold <= sat_val;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (tick && state != ST_IDLE) overrun <= 1'b1;
        end
    end

    logic [SAMPLE_W-1:0] shreg;
    logic [BC_W-1:0]     bcnt;
    logic                ser_bit;

    // bcnt parks at SAMPLE_W so the line stays low until the first LRCLK edge after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            shreg   <= '0;
            bcnt    <= BC_W'(SAMPLE_W);
            ser_bit <= 1'b0;
            Dout    <= 1'b0;
        end else begin
            if (lr_edge) begin
                shreg   <= sample_hold;
                bcnt    <= '0;
                ser_bit <= 1'b0;
            end else if (sclk_fall) begin
                if (bcnt < BC_W'(SAMPLE_W)) begin
                    ser_bit <= shreg[SAMPLE_W-1];
                    shreg   <= shreg << 1;
                    bcnt    <= bcnt + 1'b1;
                end else begin
                    ser_bit <= 1'b0;
                end
            end
            Dout <= bypass ? din_s2 : ser_bit;
        end
    end
endmodule
